// File: rtl/clk_source_pkg.sv
// Shared constants for the NoC clock/reset source: parameter defaults,
// legal parameter ranges and the hold counter width.
package clk_source_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 8;

    localparam int HOLD_CYCLES_DEF = 4;
    localparam int HOLD_CYCLES_MIN = 0;
    localparam int HOLD_CYCLES_MAX = 255;

    // Wide enough to hold HOLD_CYCLES_MAX without wrapping.
    localparam int HOLD_W = 8;

    function automatic bit params_legal(int sync_stages, int hold_cycles);
        return (sync_stages >= SYNC_STAGES_MIN) && (sync_stages <= SYNC_STAGES_MAX) &&
               (hold_cycles >= HOLD_CYCLES_MIN) && (hold_cycles <= HOLD_CYCLES_MAX);
    endfunction

endpackage

// File: rtl/clk_source_if.sv
// Clock/reset bundle delivered to the NoC domain. The source drives it
// through the master modport; NoC blocks consume it through the slave one.
interface clk_source_if;

    logic clk;
    logic rst;

    modport master (output clk, output rst);
    modport slave  (input  clk, input  rst);

endinterface

// File: rtl/clk_source_reset_sync.sv
// Reset release synchronizer: a flop chain that is preset to all ones by
// arst and shifts in zeros on each clk rising edge.
module reset_sync #(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic arst,
    output logic sync_out
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    // Shift a zero in at the bottom of the chain each edge.
    always_comb begin
        chain_d    = '0;
        chain_d[0] = 1'b0;
        for (int i = 1; i < STAGES; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    // Chain register, preset to all ones while arst is high.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            chain_q <= '1;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign sync_out = chain_q[STAGES-1];

endmodule

// File: rtl/clk_source.sv
// NoC clock/reset source: passes clk_in straight through and generates a
// reset that asserts asynchronously and releases SYNC_STAGES+HOLD_CYCLES
// rising edges after reset_in falls.
module clk_source
    import clk_source_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
    input  logic clk_in,
    input  logic reset_in,
    output logic clk_out,
    output logic reset_out
);

    if (!params_legal(SYNC_STAGES, HOLD_CYCLES)) begin : g_bad_params
        $error("clk_source: SYNC_STAGES must be %0d..%0d and HOLD_CYCLES %0d..%0d",
               SYNC_STAGES_MIN, SYNC_STAGES_MAX, HOLD_CYCLES_MIN, HOLD_CYCLES_MAX);
    end

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(HOLD_CYCLES);

    logic              sync_out;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic              reset_out_q;
    logic              reset_out_d;

    assign clk_out = clk_in;

    // The reset_out flop acts as the last synchronizer stage, so the
    // sub-module chain is one flop shorter. That lands the release exactly
    // on edge SYNC_STAGES+HOLD_CYCLES, including the HOLD_CYCLES=0 case.
    reset_sync #(
        .STAGES (SYNC_STAGES - 1)
    ) u_reset_sync (
        .clk      (clk_in),
        .arst     (reset_in),
        .sync_out (sync_out)
    );

    // Saturating hold count once the chain has flushed; release is sticky.
    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        reset_out_d = reset_out_q;
        if (!sync_out) begin
            if (hold_cnt_q != HOLD_LIMIT) begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end else begin
                reset_out_d = 1'b0;
            end
        end
    end

    // Hold counter cleared and reset_out set while reset_in is high.
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            hold_cnt_q  <= '0;
            reset_out_q <= 1'b1;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            reset_out_q <= reset_out_d;
        end
    end

    assign reset_out = reset_out_q;

endmodule

// File: tb/tb_clk_source.sv
// Directed bench for clk_source: default build (6-edge release) and a
// SYNC_STAGES=3 / HOLD_CYCLES=0 build (3-edge release) share clk_in/reset_in.
module tb_clk_source;

    logic clk_in;
    logic clk_en;
    logic reset_in;
    logic clk3;
    logic reset3;
    int   n_vec;
    int   n_err;
    int   rst_rise;
    int   rst3_rise;

    clk_source_if noc_if ();

    clk_source dut (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .clk_out   (noc_if.clk),
        .reset_out (noc_if.rst)
    );

    clk_source #(
        .SYNC_STAGES (3),
        .HOLD_CYCLES (0)
    ) dut3 (
        .clk_in    (clk_in),
        .reset_in  (reset_in),
        .clk_out   (clk3),
        .reset_out (reset3)
    );

    initial begin
        clk_in = 1'b0;
        forever begin
            #5;
            if (clk_en) clk_in = ~clk_in;
        end
    end

    always @(posedge noc_if.rst) rst_rise++;
    always @(posedge reset3) rst3_rise++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        #1;
        n_vec++;
        if (noc_if.rst !== 1'b1) begin
            n_err++; $display("FAIL reset_first dut: got %b want 1", noc_if.rst);
        end
        n_vec++;
        if (reset3 !== 1'b1) begin
            n_err++; $display("FAIL reset_first dut3: got %b want 1", reset3);
        end
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk_in); #1;
            n_vec++;
            if (noc_if.rst !== 1'b1) begin
                n_err++; $display("FAIL reset_hold c%0d: got %b want 1", c, noc_if.rst);
            end
            n_vec++;
            if (noc_if.clk !== clk_in || clk3 !== clk_in) begin
                n_err++; $display("FAIL clk_copy c%0d: got %b/%b want %b", c, noc_if.clk, clk3, clk_in);
            end
        end
    endtask

    task automatic test_release();
        @(negedge clk_in);
        reset_in = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk_in); #1;
            n_vec++;
            if (noc_if.rst !== ((e < 6) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL release edge%0d dut: got %b want %b", e, noc_if.rst, (e < 6));
            end
            n_vec++;
            if (reset3 !== ((e < 3) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL release edge%0d dut3: got %b want %b", e, reset3, (e < 3));
            end
            n_vec++;
            if (noc_if.clk !== 1'b1) begin
                n_err++; $display("FAIL clk_copy rise%0d: got %b want 1", e, noc_if.clk);
            end
        end
    endtask

    task automatic test_stable();
        int r0;
        int r3;
        r0 = rst_rise;
        r3 = rst3_rise;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk_in); #1;
            n_vec++;
            if (noc_if.rst !== 1'b0 || reset3 !== 1'b0) begin
                n_err++; $display("FAIL stable c%0d: got %b/%b want 0/0", c, noc_if.rst, reset3);
            end
            @(negedge clk_in); #1;
            n_vec++;
            if (noc_if.clk !== 1'b0 || clk3 !== 1'b0) begin
                n_err++; $display("FAIL clk_copy fall%0d: got %b/%b want 0/0", c, noc_if.clk, clk3);
            end
        end
        n_vec++;
        if (rst_rise !== r0) begin
            n_err++; $display("FAIL glitch dut: got %0d rises want %0d", rst_rise, r0);
        end
        n_vec++;
        if (rst3_rise !== r3) begin
            n_err++; $display("FAIL glitch dut3: got %0d rises want %0d", rst3_rise, r3);
        end
    endtask

    task automatic test_async_assert();
        @(negedge clk_in);
        #2;
        reset_in = 1'b1;
        #1;
        n_vec++;
        if (noc_if.rst !== 1'b1 || reset3 !== 1'b1) begin
            n_err++; $display("FAIL async_assert: got %b/%b want 1/1", noc_if.rst, reset3);
        end
        n_vec++;
        if (clk_in !== 1'b0) begin
            n_err++; $display("FAIL async_assert_noedge: clk got %b want 0", clk_in);
        end
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk_in); #1;
            n_vec++;
            if (noc_if.rst !== 1'b1 || reset3 !== 1'b1) begin
                n_err++; $display("FAIL async_hold c%0d: got %b/%b want 1/1", c, noc_if.rst, reset3);
            end
        end
    endtask

    task automatic test_reassert();
        @(negedge clk_in);
        reset_in = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk_in); #1;
            n_vec++;
            if (noc_if.rst !== 1'b1) begin
                n_err++; $display("FAIL reassert_pre edge%0d dut: got %b want 1", e, noc_if.rst);
            end
            n_vec++;
            if (reset3 !== ((e < 3) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL reassert_pre edge%0d dut3: got %b want %b", e, reset3, (e < 3));
            end
        end
        #2;
        reset_in = 1'b1;
        #1;
        n_vec++;
        if (noc_if.rst !== 1'b1 || reset3 !== 1'b1) begin
            n_err++; $display("FAIL reassert_now: got %b/%b want 1/1", noc_if.rst, reset3);
        end
        @(posedge clk_in); #1;
        n_vec++;
        if (noc_if.rst !== 1'b1 || reset3 !== 1'b1) begin
            n_err++; $display("FAIL reassert_hold: got %b/%b want 1/1", noc_if.rst, reset3);
        end
        @(negedge clk_in);
        reset_in = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk_in); #1;
            n_vec++;
            if (noc_if.rst !== ((e < 6) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL reassert_rel edge%0d dut: got %b want %b", e, noc_if.rst, (e < 6));
            end
            n_vec++;
            if (reset3 !== ((e < 3) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL reassert_rel edge%0d dut3: got %b want %b", e, reset3, (e < 3));
            end
        end
    endtask

    task automatic test_stopped_clock();
        @(negedge clk_in);
        clk_en = 1'b0;
        #3;
        reset_in = 1'b1;
        #1;
        n_vec++;
        if (noc_if.rst !== 1'b1 || reset3 !== 1'b1) begin
            n_err++; $display("FAIL stopped_pulse: got %b/%b want 1/1", noc_if.rst, reset3);
        end
        #1;
        reset_in = 1'b0;
        #22;
        n_vec++;
        if (noc_if.rst !== 1'b1 || reset3 !== 1'b1) begin
            n_err++; $display("FAIL stopped_hold: got %b/%b want 1/1", noc_if.rst, reset3);
        end
        n_vec++;
        if (noc_if.clk !== 1'b0) begin
            n_err++; $display("FAIL stopped_clk_out: got %b want 0", noc_if.clk);
        end
        clk_en = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk_in); #1;
            n_vec++;
            if (noc_if.rst !== ((e < 6) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL restart edge%0d dut: got %b want %b", e, noc_if.rst, (e < 6));
            end
            n_vec++;
            if (reset3 !== ((e < 3) ? 1'b1 : 1'b0)) begin
                n_err++; $display("FAIL restart edge%0d dut3: got %b want %b", e, reset3, (e < 3));
            end
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_rise  = 0;
        rst3_rise = 0;
        reset_in  = 1'b1;
        clk_en    = 1'b1;
        test_reset();
        test_release();
        test_stable();
        test_async_assert();
        test_reassert();
        test_stopped_clock();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clk_source.md
CLK_SOURCE -- requirements
Module: clk_source

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on the reset release path (legal range 2..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, meaning the extra clk_in rising edges that reset_out stays high after synchronization (legal range 0..255).
REQ-003 SHALL have port clk_in, input, 1 bit: the single system clock; all sequential logic uses its rising edge.
REQ-004 SHALL have port reset_in, input, 1 bit: the system reset, asynchronous and active-high.
REQ-005 SHALL have port clk_out, output, 1 bit: the clock delivered to the NoC domain.
REQ-006 SHALL have port reset_out, output, 1 bit: the reset delivered to the NoC domain, active-high.
REQ-007 SHALL use one clock (clk_in); reset (reset_in) SHALL be asynchronous and active-high.

Function
REQ-008 SHALL drive clk_out as a direct combinational copy of clk_in, with no gating, division, inversion or registering.
REQ-009 SHALL assert reset_out asynchronously: reset_out becomes 1 as soon as reset_in rises, without waiting for a clk_in edge.
REQ-010 SHALL hold reset_out at 1 for as long as reset_in is 1, whether or not clk_in is toggling.
REQ-011 SHALL deassert reset_out synchronously to a clk_in rising edge.
REQ-012 SHALL count the first clk_in rising edge with reset_in low as edge 1; reset_out SHALL fall exactly on edge N = SYNC_STAGES + HOLD_CYCLES. With the default parameters, N = 6.
REQ-013 SHALL implement the release path as follows:
- a SYNC_STAGES-deep flop chain, asynchronously preset to 1, that shifts in 0 on each edge;
- followed by a saturating hold counter, asynchronously cleared, that increments only while the chain output is 0;
- reset_out is the output of a flop, asynchronously set to 1, and is never driven by combinational logic.
REQ-014 SHALL, when HOLD_CYCLES = 0, deassert reset_out on edge SYNC_STAGES.
REQ-015 SHALL restart the full release sequence if reset_in rises during the release sequence: reset_out goes back to 1 immediately and the chain and counter are re-armed.
REQ-016 SHALL treat a reset_in pulse shorter than one clk_in period as a full reset: reset_out asserts and then releases after N edges.
REQ-017 SHALL keep reset_out at a stable 0 once it is released, for as long as reset_in stays low; it SHALL be glitch-free and never return to 1 without reset_in.
REQ-018 SHALL stop the hold counter at HOLD_CYCLES; it SHALL NOT wrap around.
REQ-019 SHALL raise an elaboration-time error if SYNC_STAGES or HOLD_CYCLES is outside its legal range.

Reset
REQ-020 SHALL put every internal flop into its reset state asynchronously while reset_in = 1:
- synchronizer chain all 1;
- hold counter 0;
- reset_out flop 1.
REQ-021 SHALL have no power-on-only state: all state SHALL be fully defined by reset_in, and reset_out SHALL be 1 from the first assertion of reset_in.

Structure
REQ-022 SHALL take its default values for SYNC_STAGES and HOLD_CYCLES, and their legal range limits, from the shared package clk_source_pkg.
REQ-023 SHALL place the synchronizer chain in one sub-module, reset_sync (parameter STAGES; ports clk, arst, sync_out).
REQ-024 SHALL implement the hold counter and output flop inline in clk_source.

Verification
REQ-025 Defaults, free-running clk_in: reset_in high for 3 cycles, then low -> reset_out = 1 throughout; reset_out falls on the 6th rising edge after release; clk_out tracks clk_in at every edge.
REQ-026 Defaults: assert reset_in mid-cycle, between clk edges -> reset_out = 1 within the same time step, before the next edge.
REQ-027 Defaults: re-assert reset_in at release edge 4, hold it for 1 cycle, then release -> reset_out never drops early; it falls on the 6th edge after the second release.
REQ-028 SYNC_STAGES = 3, HOLD_CYCLES = 0: release reset_in -> reset_out falls on edge 3.
REQ-029 Defaults, clk_in stopped: pulse reset_in for 2 ns, then restart the clock -> reset_out = 1 while the clock is stopped; reset_out falls on the 6th edge after the restart.
REQ-030 After release, 100 cycles with reset_in low -> reset_out stays 0 with no glitches.
